// File: rtl/ahb_pkg.sv
// Shared AHB encodings, the SRAM responder state type and the byte-lane mask helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic HWRITE_READ  = 1'b0;
  localparam logic HWRITE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // 2^size consecutive lanes starting at lane off (little-endian), for up to 8 lanes.
  function automatic logic [7:0] size_mask(input logic [2:0] off, input logic [2:0] size);
    logic [15:0] m;
    m = ((16'd1 << (16'd1 << size)) - 16'd1) << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-addressed byte-lane memory: byte-enable write port and asynchronous read port,
// shaped so it can be replaced by a compiled SRAM macro.
module ahb_sram_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [DW/8-1:0]          byte_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  for (genvar gi = 0; gi < DW / 8; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (byte_en[gi]) begin
        lane_mem[addr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB responder backed by on-chip memory: pipelined address/data phases, programmable
// wait states, byte-lane writes and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETN,
  input  logic            HSEL,
  input  logic [AW-1:0]   HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [DW/8-1:0] HWSTRB,
  input  logic [DW-1:0]   HWDATA,
  input  logic            HREADY_I,
  output logic            HREADY_O,
  output logic            HRESP,
  output logic [DW-1:0]   HRDATA
);

  localparam int NB    = DW / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_M1 = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  slave_state_e     state_reg, state_next, entry_state;
  logic [3:0]       cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [2:0]       off_reg;
  logic [2:0]       size_reg;
  logic             write_reg;

  logic             ready;
  logic             accept;
  logic             legal;
  logic [7:0]       lane_mask;
  logic [NB-1:0]    byte_en;
  logic [DW-1:0]    rdata;
  logic             unused;

  // Only cycles in which this slave is itself ready can open a new address phase.
  assign accept = HSEL & HREADY_I & HTRANS[1] & ready;

  always_comb begin
    legal = 1'b1;
    if ((HADDR >> OFF_W) >= AW'(DEPTH)) legal = 1'b0;
    if (HSIZE > 3'(OFF_W)) legal = 1'b0;
    if ((HADDR & ((AW'(1) << HSIZE) - AW'(1))) != '0) legal = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      off_reg   <= '0;
      size_reg  <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        idx_reg   <= HADDR[OFF_W +: IDX_W];
        off_reg   <= HADDR[2:0] & 3'(NB - 1);
        size_reg  <= HSIZE;
        write_reg <= HWRITE;
      end
      if (accept && legal) begin
        cnt_reg <= WAIT_M1;
      end else if (state_reg == ST_WAIT && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  always_comb begin
    entry_state = ST_IDLE;
    if (accept) begin
      if (!legal)               entry_state = ST_ERR1;
      else if (WAIT_CYCLES > 0) entry_state = ST_WAIT;
      else                      entry_state = ST_DATA;
    end
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DATA, ST_ERR2: state_next = entry_state;
      ST_WAIT: if (cnt_reg == '0) state_next = ST_DATA;
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  assign lane_mask = size_mask(off_reg, size_reg);

  always_comb begin
    ready   = 1'b1;
    HRESP   = HRESP_OKAY;
    byte_en = '0;
    HRDATA  = '0;
    case (state_reg)
      ST_WAIT: ready = 1'b0;
      ST_DATA: begin
        if (write_reg) byte_en = HWSTRB & lane_mask[NB-1:0];
        else           HRDATA  = rdata;
      end
      ST_ERR1: begin
        ready = 1'b0;
        HRESP = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  assign HREADY_O = ready;

  ahb_sram_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (HCLK),
    .byte_en (byte_en),
    .addr    (idx_reg),
    .wdata   (HWDATA),
    .rdata   (rdata)
  );

  // Burst type and the SEQ/NONSEQ distinction carry no meaning for this slave.
  assign unused = ^{HBURST, HTRANS[0], lane_mask};

endmodule
